// File: rtl/rx_header_parser_pkg.sv
// rx_header_parser_pkg: shared header layout, RX FSM states and Ethernet constants
package rx_header_parser_pkg;
    localparam int          HDR_BYTES = 14;
    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] eth_type;
    } header;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} rx_state_t;
endpackage

// File: rtl/rx_header_parser_shift.sv
// rx_shift_reg: shift-in register assembling the 14-byte header, first byte ends up most significant
// Ports: clk, rst (sync, active-high); clr restarts assembly; en shifts din in;
// hdr_nxt is the full 112-bit header as it stands once din is shifted in.
module rx_shift_reg
    import rx_header_parser_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [7:0]   din,
    output logic [111:0] hdr_nxt
);
    // Only 13 bytes are ever stored: the 14th is consumed straight from din
    // by the filter and the header capture in the same cycle.
    logic [103:0] q;

    assign hdr_nxt = {q, din};

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else
            q <= clr ? {96'b0, en ? din : 8'b0} : en ? hdr_nxt[103:0] : q;
    end
endmodule

// File: rtl/rx_header_parser.sv
// rx_header_parser: deserialises the Ethernet header, filters on destination MAC, forwards payload
// Ports: clk, rst (sync, active-high); rx_t* is the MAC RX byte stream (rx_tuser = bad frame at tlast);
// rx_header/hdr_valid report each accepted header; pay_t* carries the payload one cycle later;
// frame_done/frame_good report end of an accepted frame; drop_cnt counts dropped frames (saturating).
module rx_header_parser
    import rx_header_parser_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
    parameter bit          PROMISC   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_tdata,
    input  logic        rx_tvalid,
    input  logic        rx_tlast,
    input  logic        rx_tuser,
    output header       rx_header,
    output logic        hdr_valid,
    output logic [7:0]  pay_tdata,
    output logic        pay_tvalid,
    output logic        pay_tlast,
    output logic        frame_done,
    output logic        frame_good,
    output logic [15:0] drop_cnt
);
    rx_state_t   state, state_nxt;
    logic [3:0]  byte_cnt, byte_cnt_nxt;
    header       hdr_nxt;
    logic        last_hdr, match, hdr_fire, pay_beat, pay_end, drop_inc;

    rx_shift_reg u_shift (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == IDLE),
        .en      (rx_tvalid && (state == IDLE || state == HDR)),
        .din     (rx_tdata),
        .hdr_nxt (hdr_nxt)
    );

    assign last_hdr = state == HDR && byte_cnt == 4'(HDR_BYTES - 1);
    assign match    = PROMISC || hdr_nxt.dst_mac == LOCAL_MAC || hdr_nxt.dst_mac == BCAST_MAC;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            byte_cnt <= '0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
        end
    end

    // Any tlast ends the frame, so a runt arriving in IDLE or HDR falls straight back to IDLE.
    always_comb begin
        state_nxt = !rx_tvalid ? state :
                    rx_tlast ? IDLE :
                    state == IDLE ? HDR :
                    state != HDR ? state :
                    !last_hdr ? HDR :
                    match ? PAYLOAD : DROP;
    end

    always_comb begin
        hdr_fire     = rx_tvalid && last_hdr && !rx_tlast && match;
        pay_beat     = rx_tvalid && state == PAYLOAD;
        pay_end      = pay_beat && rx_tlast;
        drop_inc     = rx_tvalid && rx_tlast && (state != PAYLOAD || rx_tuser);
        byte_cnt_nxt = state == IDLE ? {3'b0, rx_tvalid} :
                       state == HDR && rx_tvalid ? byte_cnt + 4'd1 : byte_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_header  <= '0;
            hdr_valid  <= 1'b0;
            pay_tdata  <= '0;
            pay_tvalid <= 1'b0;
            pay_tlast  <= 1'b0;
            frame_done <= 1'b0;
            frame_good <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            rx_header  <= hdr_fire ? hdr_nxt : rx_header;
            hdr_valid  <= hdr_fire;
            pay_tdata  <= pay_beat ? rx_tdata : pay_tdata;
            pay_tvalid <= pay_beat;
            pay_tlast  <= pay_end;
            frame_done <= pay_end;
            frame_good <= pay_end && !rx_tuser;
            drop_cnt   <= drop_inc && drop_cnt != 16'hFFFF ? drop_cnt + 16'd1 : drop_cnt;
        end
    end
endmodule

// File: doc/rx_header_parser.md
# rx_header_parser

Receive-side counterpart of the transmitter's header shift register. Sits on the tri-mode Ethernet MAC RX AXI-Stream byte interface. Deserialises the first 14 bytes of each frame into a `header` struct and filters on destination MAC. Forwards the payload bytes of accepted frames and reports end-of-frame status and a drop count.

## Interface
Parameters:
- `LOCAL_MAC`, default 48'h02_00_00_00_00_01: station address accepted as destination.
- `PROMISC`, default 1'b0: 1 = accept any destination.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `rx_tdata` in 8: RX byte from MAC.
- `rx_tvalid` in 1: byte valid. No tready exists; every valid byte is consumed.
- `rx_tlast` in 1: last byte of frame.
- `rx_tuser` in 1: bad-frame flag, meaningful only with `rx_tlast`.
- `rx_header` out `header` (112): captured {dst_mac, src_mac, eth_type}. Held until the next capture.
- `hdr_valid` out 1: one-cycle pulse when `rx_header` updates.
- `pay_tdata` out 8: payload byte.
- `pay_tvalid` out 1: payload byte valid.
- `pay_tlast` out 1: last payload byte.
- `frame_done` out 1: one-cycle pulse at the end of an accepted frame.
- `frame_good` out 1: valid with `frame_done`; equals `!rx_tuser` at tlast.
- `drop_cnt` out 16: dropped-frame count, saturating.

## Operation
- FSM states: IDLE, HDR, PAYLOAD, DROP. All transitions occur only on a `rx_tvalid` beat.
- **IDLE**, on beat:
  - shift byte in;
  - `byte_cnt` <= 1;
  - go to HDR. If `rx_tlast` is also set, treat as runt: go to IDLE and increment `drop_cnt`.
- **HDR**, on beat:
  - Shift in with `shreg <= {shreg[103:0], rx_tdata}`. The first byte received becomes dst_mac[47:40], which inverts the transmitter's MSB-first byte rotation.
  - `byte_cnt` increments on each beat.
- **HDR, 14th byte** (`byte_cnt==13`):
  - If `rx_tlast`: runt. Go to IDLE and increment `drop_cnt`. Header-only frames are runts.
  - Otherwise, test the assembled dst_mac. It matches when it equals `LOCAL_MAC`, equals 48'hFFFF_FFFF_FFFF, or `PROMISC==1`.
  - On match: latch `rx_header`, pulse `hdr_valid`, go to PAYLOAD.
  - Otherwise: go to DROP.
- **HDR, early tlast** (before byte 14): runt. Go to IDLE and increment `drop_cnt`.
- **PAYLOAD**, on beat:
  - forward the byte to the `pay_*` outputs;
  - on `rx_tlast`: assert `pay_tlast`, pulse `frame_done`, set `frame_good = !rx_tuser`, go to IDLE. A bad frame also increments `drop_cnt`.
- **DROP**: discard bytes; `pay_*` stays silent. On `rx_tlast`: increment `drop_cnt`, go to IDLE.
- **Counter**: `byte_cnt` is 4 bits, wraps never (cleared in IDLE).
- **`drop_cnt`**: saturates at 16'hFFFF; at most one increment per cycle.
- **Gaps**: `rx_tvalid` low mid-frame holds the state, counter and shift register.

## Timing
- Reset values: `hdr_valid`=0, `pay_tvalid`=0, `pay_tlast`=0, `pay_tdata`=0, `frame_done`=0, `frame_good`=0, `rx_header`=0, `drop_cnt`=0, FSM=IDLE, `byte_cnt`=0.
- Byte 14 accepted at cycle N: `hdr_valid`=1 and `rx_header` are valid at N+1.
- Payload latency is one cycle, fully registered: beat at cycle M appears on `pay_*` at M+1.
- `frame_done` and `frame_good` coincide with `pay_tlast`.
- Back-to-back frames with tlast at cycle M and a new first byte at M+1 are handled with no lost bytes. IDLE consumes the M+1 beat.
- `rst` mid-frame: the next cycle is IDLE with all outputs at reset values. Any remaining bytes of the interrupted frame are parsed as a new frame. System reset also resets the MAC, so this case does not occur in normal operation.

## Structure
- Shared package (the one already holding `header`):
  - `header` packed struct;
  - `rx_state_t` enum;
  - `HDR_BYTES = 14`;
  - `BCAST_MAC = 48'hFFFF_FFFF_FFFF`.
- Natural sub-module: `rx_shift_reg`, the 112-bit shift-in register with shift enable and clear. It mirrors the TX shift register.
- The FSM, filter, counters and payload pipeline live in `rx_header_parser`.

## Test plan
- **Unicast accept**: dst=02:00:00:00:00:01, src=AA:BB:CC:DD:EE:FF, type=16'h0800, payload 46 bytes 00..2D, no gaps.
  - `hdr_valid` is one cycle after byte 14, with `rx_header`={48'h020000000001, 48'hAABBCCDDEEFF, 16'h0800}.
  - 46 `pay_*` bytes arrive in order, `pay_tlast` on 8'h2D, `frame_done` with `frame_good`=1.
- **Broadcast and filtering**:
  - dst=FF..FF: accepted.
  - dst=02:00:00:00:00:02: no `hdr_valid`, no `pay_tvalid`, `drop_cnt`=1.
  - Same mismatched frame with `PROMISC`=1: accepted.
- **Runts**:
  - 10-byte frame: `drop_cnt` 0→1.
  - 14-byte frame (tlast on byte 14): `drop_cnt` 1→2, no `hdr_valid`.
  - 1-byte frame: `drop_cnt` 2→3.
- **Bad FCS**: accepted frame ending with `rx_tuser`=1 gives `frame_done`=1, `frame_good`=0, `drop_cnt`+1.
- **Gaps and back-to-back**:
  - Random `rx_tvalid` low cycles inside header and payload: output is identical to the gapless run.
  - Two frames with zero idle between them: both headers and payloads are correct.
- **Reset and saturation**:
  - `rst` asserted at payload byte 20: all outputs reach reset values the next cycle.
  - `drop_cnt` preloaded to 16'hFFFE via 65534 dropped frames (or force), then 3 more drops: holds at 16'hFFFF.
